// File: rtl/axis_deadlock_monitor.sv
// Deadlock monitor for the AXI-Stream ports of one HLS instance: persistence-filtered
// block detection with per-channel direction codes, sticky flag, first channel and stall count.

module axis_ch_code (
  input  logic       sig,
  input  logic       dir,
  output logic [1:0] code
);
  assign code = {sig & dir, sig & ~dir};
endmodule

module axis_deadlock_monitor #(
  parameter  int NUM_CH    = 2,
  parameter  int THRESHOLD = 1,
  parameter  int CNT_W     = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_CH-1:0]     axis_block_sigs,
  input  logic [NUM_CH-1:0]     axis_block_dir,
  input  logic                  inst_idle,
  output logic [2*NUM_CH-1:0]   axis_block_info,
  output logic                  block,
  output logic                  deadlock_sticky,
  output logic [CH_W-1:0]       first_ch,
  output logic [CNT_W-1:0]      stall_cycles
);
  localparam logic [CNT_W:0]   THR_W     = (CNT_W+1)'(THRESHOLD);
  localparam logic [CNT_W-1:0] THR_C     = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic                raw;
  logic [CNT_W-1:0]    pcnt;
  logic [CNT_W:0]      pcnt_inc;
  logic                blk_nxt;
  logic [2*NUM_CH-1:0] code_d, code_q;
  logic [CH_W-1:0]     low_idx;

  assign raw      = (|axis_block_sigs) & ~inst_idle;
  assign pcnt_inc = {1'b0, pcnt} + (CNT_W+1)'(1);
  assign blk_nxt  = raw & (pcnt_inc >= THR_W);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_ch_code u_code (
      .sig  (axis_block_sigs[g]),
      .dir  (axis_block_dir[g]),
      .code (code_d[2*g +: 2])
    );
  end

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (axis_block_sigs[i]) low_idx = CH_W'(i);
  end

  assign axis_block_info = block ? code_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt            <= '0;
      block           <= 1'b0;
      code_q          <= '0;
      deadlock_sticky <= 1'b0;
      first_ch        <= '0;
      stall_cycles    <= '0;
    end else begin
      if (!raw)                pcnt <= '0;
      else if (pcnt != THR_C)  pcnt <= pcnt + CNT_W'(1);
      block  <= blk_nxt;
      code_q <= code_d;
      // Clear wins over a coincident detection; sticky only sets on a rising block.
      if (clear) begin
        deadlock_sticky <= 1'b0;
        first_ch        <= '0;
        stall_cycles    <= '0;
      end else begin
        if (blk_nxt && !block && !deadlock_sticky) begin
          deadlock_sticky <= 1'b1;
          first_ch        <= low_idx;
        end
        if (block && stall_cycles != STALL_MAX)
          stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_axis_deadlock_monitor.sv
// Bench for axis_deadlock_monitor: two instances (THRESHOLD=8/CNT_W=16 and THRESHOLD=1/CNT_W=4)
// driven in lockstep and compared against a run-length reference model.

module tb_axis_deadlock_monitor;
  logic       clock = 0;
  logic       reset = 1, clear = 0, idle = 0;
  logic [3:0] sigs = 0, dir = 0;

  logic       blk_a, blk_b, st_a, st_b;
  logic [7:0] info_a, info_b;
  logic [1:0] fc_a, fc_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  logic        blk_o [2];
  logic        st_o  [2];
  logic [7:0]  info_o[2];
  logic [1:0]  fc_o  [2];
  logic [15:0] stl_o [2];

  int n_tests = 0, n_fail = 0;

  // reference model state
  int   THR_M[2] = '{8, 1};
  int   SMAX[2]  = '{65535, 15};
  int   m_run[2], m_stall[2], m_first[2];
  bit   m_blk[2], m_sticky[2];
  logic [7:0] m_codes;

  always #5 clock = ~clock;

  axis_deadlock_monitor #(.NUM_CH(4), .THRESHOLD(8), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(sigs),
    .axis_block_dir(dir), .inst_idle(idle), .axis_block_info(info_a),
    .block(blk_a), .deadlock_sticky(st_a), .first_ch(fc_a), .stall_cycles(stall_a));

  axis_deadlock_monitor #(.NUM_CH(4), .THRESHOLD(1), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(sigs),
    .axis_block_dir(dir), .inst_idle(idle), .axis_block_info(info_b),
    .block(blk_b), .deadlock_sticky(st_b), .first_ch(fc_b), .stall_cycles(stall_b));

  always_comb begin
    blk_o[0] = blk_a;  blk_o[1] = blk_b;
    st_o[0]  = st_a;   st_o[1]  = st_b;
    info_o[0] = info_a; info_o[1] = info_b;
    fc_o[0]  = fc_a;   fc_o[1]  = fc_b;
    stl_o[0] = stall_a; stl_o[1] = {12'b0, stall_b};
  end

  function automatic int lowest(logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] codes_of(logic [3:0] s, logic [3:0] d);
    logic [7:0] r;
    r = 8'h0;
    for (int i = 0; i < 4; i++) if (s[i]) r[2*i +: 2] = d[i] ? 2'd2 : 2'd1;
    return r;
  endfunction

  // Advance one clock: the model consumes the inputs of the ending cycle.
  task automatic step();
    bit raw, nb;
    int n_run, lo;
    raw = (|sigs) && !idle;
    lo  = lowest(sigs);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_run[k] = 0; m_blk[k] = 0; m_sticky[k] = 0; m_first[k] = 0; m_stall[k] = 0;
      end else begin
        n_run = raw ? ((m_run[k] < 100000) ? m_run[k] + 1 : m_run[k]) : 0;
        nb    = raw && (n_run >= THR_M[k]);
        if (clear) begin
          m_sticky[k] = 0; m_first[k] = 0; m_stall[k] = 0;
        end else begin
          if (nb && !m_blk[k] && !m_sticky[k]) begin m_sticky[k] = 1; m_first[k] = lo; end
          if (m_blk[k] && m_stall[k] < SMAX[k]) m_stall[k]++;
        end
        m_run[k] = n_run;
        m_blk[k] = nb;
      end
    end
    m_codes = reset ? 8'h0 : codes_of(sigs, dir);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; step(); step();
    for (int k = 0; k < 2; k++) begin
      n_tests += 5;
      if (blk_o[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_block[%0d]: got %0h want 0", k, blk_o[k]); end
      if (info_o[k] !== 8'h0) begin n_fail++; $display("FAIL reset_info[%0d]: got %0h want 0", k, info_o[k]); end
      if (st_o[k] !== 1'b0)   begin n_fail++; $display("FAIL reset_sticky[%0d]: got %0h want 0", k, st_o[k]); end
      if (fc_o[k] !== 2'd0)   begin n_fail++; $display("FAIL reset_first[%0d]: got %0h want 0", k, fc_o[k]); end
      if (stl_o[k] !== 16'd0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %0h want 0", k, stl_o[k]); end
    end
    reset = 0; step();
  endtask

  task automatic test_persist();
    sigs = 4'b0100; dir = 4'b0000;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_tests++;
      if (blk_a !== (c >= 8)) begin n_fail++; $display("FAIL persist_block c=%0d: got %0h want %0h", c, blk_a, c >= 8); end
    end
    n_tests += 5;
    if (info_a !== 8'h10)   begin n_fail++; $display("FAIL persist_info: got %0h want 10", info_a); end
    if (st_a !== 1'b1)      begin n_fail++; $display("FAIL persist_sticky: got %0h want 1", st_a); end
    if (fc_a !== 2'd2)      begin n_fail++; $display("FAIL persist_first: got %0h want 2", fc_a); end
    if (stall_a !== 16'd12) begin n_fail++; $display("FAIL persist_stall: got %0d want 12", stall_a); end
    if (stl_o[1] !== 16'(m_stall[1])) begin n_fail++; $display("FAIL persist_stall_b: got %0d want %0d", stl_o[1], m_stall[1]); end
    sigs = 0; step(); step();
    clear = 1; step(); clear = 0;
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 15; c++) begin
      sigs = (c == 7) ? 4'b0000 : 4'b0100;
      step();
      n_tests += 2;
      if (blk_a !== 1'b0) begin n_fail++; $display("FAIL glitch_block c=%0d: got %0h want 0", c, blk_a); end
      if (st_a !== 1'b0)  begin n_fail++; $display("FAIL glitch_sticky c=%0d: got %0h want 0", c, st_a); end
    end
    sigs = 0; step(); step();
    clear = 1; step(); clear = 0;
  endtask

  task automatic test_dir_idle();
    sigs = 4'b1010; dir = 4'b1000;
    repeat (10) step();
    n_tests += 3;
    if (blk_a !== 1'b1)   begin n_fail++; $display("FAIL dir_block: got %0h want 1", blk_a); end
    if (info_a !== 8'h84) begin n_fail++; $display("FAIL dir_info: got %0h want 84", info_a); end
    if (fc_a !== 2'd1)    begin n_fail++; $display("FAIL dir_first: got %0h want 1", fc_a); end
    idle = 1; step();
    n_tests += 4;
    if (blk_a !== 1'b0)   begin n_fail++; $display("FAIL idle_block: got %0h want 0", blk_a); end
    if (info_a !== 8'h00) begin n_fail++; $display("FAIL idle_info: got %0h want 0", info_a); end
    if (st_a !== 1'b1)    begin n_fail++; $display("FAIL idle_sticky: got %0h want 1", st_a); end
    if (fc_a !== 2'd1)    begin n_fail++; $display("FAIL idle_first: got %0h want 1", fc_a); end
    idle = 0; sigs = 0; dir = 0; step();
  endtask

  task automatic test_clear();
    sigs = 4'b0001;
    repeat (10) step();
    clear = 1; step(); clear = 0;
    n_tests += 4;
    if (blk_a !== 1'b1)    begin n_fail++; $display("FAIL clear_block: got %0h want 1", blk_a); end
    if (st_a !== 1'b0)     begin n_fail++; $display("FAIL clear_sticky: got %0h want 0", st_a); end
    if (fc_a !== 2'd0)     begin n_fail++; $display("FAIL clear_first: got %0h want 0", fc_a); end
    if (stall_a !== 16'd0) begin n_fail++; $display("FAIL clear_stall: got %0d want 0", stall_a); end
    for (int c = 1; c <= 6; c++) begin
      step();
      n_tests += 2;
      if (stall_a !== 16'(c)) begin n_fail++; $display("FAIL clear_resume c=%0d: got %0d want %0d", c, stall_a, c); end
      if (st_a !== 1'b0)      begin n_fail++; $display("FAIL clear_nosticky c=%0d: got %0h want 0", c, st_a); end
    end
    sigs = 0; step(); step();
    sigs = 4'b0010;
    repeat (9) step();
    n_tests += 2;
    if (st_a !== 1'b1) begin n_fail++; $display("FAIL clear_rearm_sticky: got %0h want 1", st_a); end
    if (fc_a !== 2'd1) begin n_fail++; $display("FAIL clear_rearm_first: got %0h want 1", fc_a); end
    sigs = 0; step(); step();
    clear = 1; step(); clear = 0;
  endtask

  task automatic test_saturate();
    sigs = 4'b0100;
    step();
    n_tests++;
    if (blk_b !== 1'b1) begin n_fail++; $display("FAIL sat_latency: got %0h want 1", blk_b); end
    for (int c = 2; c <= 30; c++) begin
      step();
      n_tests++;
      if (stl_o[1] !== 16'(m_stall[1])) begin n_fail++; $display("FAIL sat_track c=%0d: got %0d want %0d", c, stl_o[1], m_stall[1]); end
    end
    n_tests++;
    if (stall_b !== 4'd15) begin n_fail++; $display("FAIL sat_final: got %0d want 15", stall_b); end
  endtask

  task automatic test_reset_mid();
    sigs = 4'b0100;
    repeat (10) step();
    reset = 1; step(); reset = 0;
    for (int k = 0; k < 2; k++) begin
      n_tests += 5;
      if (blk_o[k] !== 1'b0)  begin n_fail++; $display("FAIL rmid_block[%0d]: got %0h want 0", k, blk_o[k]); end
      if (info_o[k] !== 8'h0) begin n_fail++; $display("FAIL rmid_info[%0d]: got %0h want 0", k, info_o[k]); end
      if (st_o[k] !== 1'b0)   begin n_fail++; $display("FAIL rmid_sticky[%0d]: got %0h want 0", k, st_o[k]); end
      if (fc_o[k] !== 2'd0)   begin n_fail++; $display("FAIL rmid_first[%0d]: got %0h want 0", k, fc_o[k]); end
      if (stl_o[k] !== 16'd0) begin n_fail++; $display("FAIL rmid_stall[%0d]: got %0h want 0", k, stl_o[k]); end
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      n_tests += 2;
      if (blk_a !== (c >= 8)) begin n_fail++; $display("FAIL rmid_rearm_a c=%0d: got %0h want %0h", c, blk_a, c >= 8); end
      if (blk_b !== 1'b1)     begin n_fail++; $display("FAIL rmid_rearm_b c=%0d: got %0h want 1", c, blk_b); end
    end
    sigs = 0; step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) sigs = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
      dir   = 4'($urandom);
      idle  = ($urandom_range(0, 29) == 0);
      clear = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        n_tests += 5;
        if (blk_o[k] !== m_blk[k]) begin n_fail++; $display("FAIL rnd_block[%0d] c=%0d: got %0h want %0h", k, c, blk_o[k], m_blk[k]); end
        if (info_o[k] !== (m_blk[k] ? m_codes : 8'h0)) begin n_fail++; $display("FAIL rnd_info[%0d] c=%0d: got %0h want %0h", k, c, info_o[k], m_blk[k] ? m_codes : 8'h0); end
        if (st_o[k] !== m_sticky[k]) begin n_fail++; $display("FAIL rnd_sticky[%0d] c=%0d: got %0h want %0h", k, c, st_o[k], m_sticky[k]); end
        if (fc_o[k] !== 2'(m_first[k])) begin n_fail++; $display("FAIL rnd_first[%0d] c=%0d: got %0h want %0h", k, c, fc_o[k], m_first[k]); end
        if (stl_o[k] !== 16'(m_stall[k])) begin n_fail++; $display("FAIL rnd_stall[%0d] c=%0d: got %0d want %0d", k, c, stl_o[k], m_stall[k]); end
      end
    end
    reset = 0; clear = 0; idle = 0;
  endtask

  initial begin
    test_reset();
    test_persist();
    test_glitch();
    test_dir_idle();
    test_clear();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_deadlock_monitor.md
Name: axis_deadlock_monitor

Overview:
Parametrised deadlock monitor for the AXI-Stream ports of one HLS instance in the co-simulation bench. It watches per-channel blocking flags and declares a deadlock only after blocking persists for a programmable number of cycles; idle instances never report. It reports per-channel block direction, a sticky deadlock flag, the first blocked channel and a saturating stall-cycle count. This generalises the fixed 2-channel, 1-cycle monitor to N channels with persistence filtering and diagnostics.

Parameters:
NUM_CH, 2, number of monitored AXIS channels (1..64)
THRESHOLD, 1, consecutive blocked cycles required before block asserts (>=1)
CNT_W, 16, width of persistence and stall counters; THRESHOLD < 2**CNT_W
CH_W, derived = max(1, clog2(NUM_CH)), width of first_ch (localparam)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous clear of sticky flag, first_ch, stall_cycles
axis_block_sigs  in  NUM_CH  bit i = channel i currently blocked
axis_block_dir  in  NUM_CH  bit i: 0 = blocked reading (empty), 1 = blocked writing (full)
inst_idle  in  1  monitored instance idle
axis_block_info  out  2*NUM_CH  per-channel code, bits [2i+1:2i]
block  out  1  live deadlock indication
deadlock_sticky  out  1  latched: deadlock seen since last clear/reset
first_ch  out  CH_W  lowest-index blocked channel at detection
stall_cycles  out  CNT_W  cycles block was high since last clear, saturating

Behaviour:
- Reset (interface as decided: reset reset, synchronous, active-high; clock clock): all outputs 0, persistence counter 0.
- raw = (|axis_block_sigs) & ~inst_idle.
- Persistence counter pcnt: raw=0 -> 0; raw=1 -> pcnt+1, saturating at THRESHOLD.
- block registered: next block = raw & (pcnt+1 >= THRESHOLD). Asserts in cycle T+THRESHOLD when raw first high in cycle T and held; THRESHOLD=1 gives 1-cycle latency. Deasserts in cycle after raw drops (no hysteresis).
- Per-channel code, registered each cycle: 2'b00 not blocked; 2'b01 blocked on read (block_sigs[i]=1, dir[i]=0); 2'b10 blocked on write (dir[i]=1). axis_block_info = codes when block=1, else all zeros (gated combinationally by block register).
- inst_idle=1 forces raw=0 same cycle: pcnt clears, block drops next cycle.
- Sticky: deadlock_sticky sets in the cycle block rises (0->1 at register update); first_ch captured at the same update from the lowest-index set bit of axis_block_sigs in the detecting cycle. Later deadlocks do not overwrite first_ch while sticky=1.
- stall_cycles: +1 each cycle block=1, saturates at 2**CNT_W-1; never wraps.
- clear: next cycle deadlock_sticky=0, first_ch=0, stall_cycles=0. Does not affect pcnt or block. Clear coincident with a detection: clear wins for that cycle; since block is already 1 the following cycle no re-set occurs (sticky sets only on rising edge of block).
- Reset mid-deadlock: all state 0 next cycle; detection restarts from pcnt=0.
- Channel-set changes during persistent blocking (different channels blocked, raw stays 1) do not restart pcnt.

Test Plan:
- NUM_CH=4, THRESHOLD=8: block_sigs=4'b0100, dir=0, idle=0 held 20 cycles -> block rises exactly 8 cycles after first assertion; axis_block_info=8'h10; sticky=1; first_ch=2; stall_cycles=12 at end.
- Same setup, block_sigs high 7 cycles then 0 one cycle then 7 cycles -> block never asserts, sticky stays 0.
- block_sigs=4'b1010, dir=4'b1000, held past threshold -> axis_block_info=8'h84, first_ch=1; then inst_idle=1 -> block=0 and info=0 next cycle, sticky remains 1, first_ch remains 1.
- After detection, pulse clear while block high -> sticky=0, first_ch=0, stall_cycles=0 next cycle, then stall_cycles resumes counting from 1; sticky not re-set until block falls and rises again.
- CNT_W=4, THRESHOLD=1, block held 30 cycles -> block 1 cycle after raw; stall_cycles saturates at 15, no wrap.
- Assert reset during active deadlock -> all outputs 0 next cycle; with block still held, block re-asserts THRESHOLD cycles after reset release.
